// File: rtl/uart_pkg.sv
// Shared types and default parameters for the UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;

endpackage

// File: rtl/rx_tick_counter.sv
// Modulo-MODULUS oversample counter with clear, tick-gated increment,
// and terminal-count / half-count flags.
module rx_tick_counter #(
  parameter int MODULUS = 16,
  parameter int W       = $clog2(MODULUS)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic term,
  output logic half
);

  logic [W-1:0] count;

  assign term = (count == W'(MODULUS - 1));
  assign half = (count == W'(MODULUS / 2 - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= term ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: finds the start bit, strobes each data bit at
// mid-bit into the shift register and flags the stop-bit outcome.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  input  logic tick,
  output logic shift_en,
  output logic rx_bit,
  output logic wr_en,
  output logic frame_err,
  output logic busy
);

  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_START = START;
  localparam logic [1:0] S_DATA  = DATA;
  localparam logic [1:0] S_STOP  = STOP;

  logic [1:0]    state;
  logic [BW-1:0] bit_cnt;
  logic          os_clear;
  logic          os_inc;
  logic          os_term;
  logic          os_half;

  rx_tick_counter #(
    .MODULUS (OVERSAMPLE)
  ) u_os_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (os_clear),
    .inc   (os_inc),
    .term  (os_term),
    .half  (os_half)
  );

  assign busy = (state != S_IDLE);

  // Start bit is judged at its midpoint; data and stop bits one full bit later.
  always_comb begin
    os_clear = 1'b0;
    os_inc   = 1'b0;
    if (tick) begin
      case (state)
        S_IDLE:  os_clear = 1'b1;
        S_START: if (os_half) os_clear = 1'b1; else os_inc = 1'b1;
        S_DATA,
        S_STOP:  if (os_term) os_clear = 1'b1; else os_inc = 1'b1;
        default: os_clear = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      shift_en  <= 1'b0;
      rx_bit    <= 1'b0;
      wr_en     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      shift_en  <= 1'b0;
      wr_en     <= 1'b0;
      frame_err <= 1'b0;
      if (tick) begin
        case (state)
          S_IDLE: begin
            if (!rx) state <= S_START;
          end
          S_START: begin
            if (os_half) begin
              if (!rx) begin
                state   <= S_DATA;
                bit_cnt <= '0;
              end else begin
                state <= S_IDLE;
              end
            end
          end
          S_DATA: begin
            if (os_term) begin
              rx_bit   <= rx;
              shift_en <= 1'b1;
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_BIT) state <= S_STOP;
            end
          end
          S_STOP: begin
            if (os_term) begin
              wr_en     <= rx;
              frame_err <= ~rx;
              state     <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: expected bits and frame outcomes are
// queued as frames are driven and consumed when the DUT pulses.
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  localparam int DB = UART_DATA_BITS;
  localparam int OS = UART_OVERSAMPLE;

  logic clk = 1'b0;
  logic reset;
  logic rx;
  logic tick;
  logic shift_en;
  logic rx_bit;
  logic wr_en;
  logic frame_err;
  logic busy;

  int checks = 0;
  int failures = 0;
  int tickDiv = 1;
  int expSpacing = OS;
  int cycleCount = 0;
  int lastShiftCycle = 0;
  int shiftIdx = 0;

  logic       expBits[$];
  logic [1:0] expFrames[$];

  uart_rx_ctrl #(
    .DATA_BITS  (DB),
    .OVERSAMPLE (OS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .tick      (tick),
    .shift_en  (shift_en),
    .rx_bit    (rx_bit),
    .wr_en     (wr_en),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Monitor samples on the falling edge, away from register updates.
  always @(negedge clk) begin
    cycleCount++;
    if (reset) begin
      shiftIdx = 0;
    end else begin
      if (shift_en) begin
        if (expBits.size() == 0) checkOutput("unexpected_shift", 1, 0);
        else checkOutput("rx_bit", rx_bit, expBits.pop_front());
        if (shiftIdx != 0 && expSpacing != 0)
          checkOutput("shift_spacing", cycleCount - lastShiftCycle, expSpacing);
        lastShiftCycle = cycleCount;
        shiftIdx = (shiftIdx + 1) % DB;
      end
      if (wr_en || frame_err) begin
        checkOutput("pulse_exclusive", {30'd0, wr_en & frame_err, shift_en}, 0);
        if (expFrames.size() == 0) checkOutput("unexpected_frame_event", {wr_en, frame_err}, 0);
        else checkOutput("frame_event", {wr_en, frame_err}, expFrames.pop_front());
      end
    end
  end

  task automatic waitTicks(input int n);
    for (int t = 0; t < n; t++) begin
      for (int i = 0; i < tickDiv; i++) begin
        tick = (i == tickDiv - 1);
        @(posedge clk);
        #1;
      end
      tick = 1'b0;
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_shift_en"}, shift_en, 0);
    checkOutput({tag, "_rx_bit"}, rx_bit, 0);
    checkOutput({tag, "_wr_en"}, wr_en, 0);
    checkOutput({tag, "_frame_err"}, frame_err, 0);
    checkOutput({tag, "_busy"}, busy, 0);
  endtask

  // Drives one frame; abortBit>=0 resets mid-bit, freezeBit>=0 stalls tick mid-bit.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                               input int idleTicks, input int abortBit,
                               input int freezeBit);
    rx = 1'b0;
    waitTicks(OS);
    for (int b = 0; b < DB; b++) begin
      if (b == abortBit) begin
        rx = data[b];
        waitTicks(OS / 4);
        reset = 1'b1;
        tick = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick = 1'b0;
        checkIdleOutputs("abort");
        rx = 1'b1;
        waitTicks(2 * OS);
        return;
      end
      expBits.push_back(data[b]);
      rx = data[b];
      if (b == freezeBit) begin
        waitTicks(OS / 2);
        tick = 1'b0;
        repeat (20) begin
          @(posedge clk);
          #1;
          checkOutput("freeze_busy", busy, 1);
        end
        waitTicks(OS / 2);
      end else begin
        waitTicks(OS);
      end
    end
    expFrames.push_back(stopBit ? 2'b10 : 2'b01);
    rx = stopBit;
    waitTicks(OS);
    rx = 1'b1;
    waitTicks(idleTicks);
  endtask

  initial begin
    reset = 1'b1;
    rx = 1'b0;
    tick = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkIdleOutputs("reset");
    reset = 1'b0;
    rx = 1'b1;
    tick = 1'b0;
    waitTicks(4);

    $display("[TB] frame 0xA5, good stop");
    applyStimulus(8'hA5, 1'b1, 4, -1, -1);
    checkOutput("a5_busy_after", busy, 0);

    $display("[TB] start-bit glitch");
    rx = 1'b0;
    waitTicks(1);
    checkOutput("glitch_busy_start", busy, 1);
    waitTicks(3);
    rx = 1'b1;
    waitTicks(4);
    checkOutput("glitch_busy_8", busy, 1);
    waitTicks(1);
    checkOutput("glitch_busy_9", busy, 0);
    waitTicks(8);

    $display("[TB] frame 0x3C, bad stop");
    applyStimulus(8'h3C, 1'b0, 24, -1, -1);
    checkOutput("ferr_busy_after", busy, 0);

    $display("[TB] reset during 0xFF, then 0x3C");
    applyStimulus(8'hFF, 1'b1, 0, 3, -1);
    checkOutput("abort_busy_after", busy, 0);
    applyStimulus(8'h3C, 1'b1, 4, -1, -1);

    $display("[TB] slow tick, 0x5A");
    tickDiv = 3;
    expSpacing = 3 * OS;
    applyStimulus(8'h5A, 1'b1, 4, -1, -1);
    expSpacing = 0;
    applyStimulus(8'h5A, 1'b1, 4, -1, 4);
    checkOutput("slow_busy_after", busy, 0);
    tickDiv = 1;
    expSpacing = OS;

    $display("[TB] back-to-back 0x01, 0x80");
    applyStimulus(8'h01, 1'b1, 0, -1, -1);
    applyStimulus(8'h80, 1'b1, 4, -1, -1);
    checkOutput("b2b_busy_after", busy, 0);

    checkOutput("bits_left", expBits.size(), 0);
    checkOutput("frames_left", expFrames.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
